tt_sweep: RTL and testbench
===========================

TT_SWEEP -- requirements
Module: tt_sweep

Interface
REQ-001 Parameter SETTLE, default 1, wait cycles after driving a vector before sampling; legal range 1..15.
REQ-002 Parameter EXP7, default 8'hBE, expected f7 truth table; bit i is the response to {x,y,z}=i.
REQ-003 Parameter EXP8, default 8'hBE, expected f8 truth table, same indexing.
REQ-004 Parameter EXP9, default 8'hBE, expected f9 truth table, same indexing.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  sweep request, level-sampled in IDLE only.
REQ-008 x, y, z  out  1 each  stimulus to the logic stage under test; {x,y,z} = current vector index.
REQ-009 f7, f8, f9  in  1 each  responses from the logic stage under test.
REQ-010 busy  out  1  high while a sweep is in progress.
REQ-011 done  out  1  one-cycle pulse at end of sweep.
REQ-012 pass  out  1  last completed sweep had zero mismatches.
REQ-013 err_cnt  out  4  number of vectors with at least one mismatching output (0..8).
REQ-014 fail_mask  out  8  bit i set when vector i mismatched.

Function
REQ-015 FSM states: IDLE, SETTLE, CHECK, DONE; 3-bit index idx; 4-bit settle counter.
REQ-016 IDLE: start=1 at edge E0 -> SETTLE, idx=0; err_cnt, fail_mask, pass cleared at E0.
REQ-017 SETTLE: held exactly SETTLE cycles, then CHECK.
REQ-018 CHECK (one cycle): compare f7/f8/f9 against EXP7[idx]/EXP8[idx]/EXP9[idx]; on any mismatch, fail_mask[idx] set and err_cnt incremented once.
REQ-019 CHECK exit: idx<7 -> idx+1, SETTLE; idx==7 -> DONE.
REQ-020 DONE: done=1 for one cycle; pass=(err_cnt==0) including the final CHECK result; -> IDLE.
REQ-021 Latency: done high in the cycle following edge E0+8*(SETTLE+1); 16 cycles at SETTLE=1.
REQ-022 {x,y,z}=idx in SETTLE and CHECK; 3'b000 in IDLE and DONE.
REQ-023 busy=1 in SETTLE and CHECK, 0 in IDLE and DONE.
REQ-024 start outside IDLE ignored, no queuing; start held high in IDLE after DONE begins a new sweep.
REQ-025 err_cnt, fail_mask, pass hold their values in IDLE until the next accepted start.
REQ-026 err_cnt saturates naturally at 8; no wrap permitted.

Reset
REQ-027 rst=1 forces IDLE immediately, regardless of clock, including mid-sweep.
REQ-028 Reset values: x=y=z=0, busy=0, done=0, pass=0, err_cnt=0, fail_mask=8'h00, idx=0, settle counter=0.
REQ-029 Sweep aborted by reset does not produce done; the next start begins at idx=0.

Configuration
REQ-030 Macro TT_SWEEP_STOP_ON_FAIL_EN defined: first mismatching CHECK goes to DONE directly; err_cnt=1, pass=0, fail_mask holds only that bit.
REQ-031 Macro undefined: all 8 vectors swept regardless of mismatches, per REQ-019.

Verification
REQ-032 SETTLE=1, DUT responses f7=f8=f9=0 only at 000 and 110, pulse start -> done at E0+16, pass=1, err_cnt=0, fail_mask=8'h00.
REQ-033 f9 stuck at 1, other outputs correct -> pass=0, err_cnt=2, fail_mask=8'h41.
REQ-034 SETTLE=3, correct responses -> busy high 32 cycles, done at E0+32; x,y,z step 000..111, each held 4 cycles.
REQ-035 start pulsed again at idx=3 -> ignored; single done at E0+16; start re-asserted after done -> new sweep with results cleared.
REQ-036 rst asserted at idx=5 mid-SETTLE -> all outputs at reset values immediately, no done; next start sweeps from 000.
REQ-037 TT_SWEEP_STOP_ON_FAIL_EN defined, f7 stuck at 0 -> first mismatch at idx 1; done at E0+4 (SETTLE=1), err_cnt=1, fail_mask=8'h02, pass=0.

Source files
------------

// File: rtl/tt_sweep_if.sv
// Truth-table sweep bus: start request, stimulus/response pins and sweep results.
// master = sweeper side, slave = logic-stage/controller side.
interface tt_sweep_if;
  logic       start;
  logic       x;
  logic       y;
  logic       z;
  logic       f7;
  logic       f8;
  logic       f9;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [7:0] fail_mask;

  modport master (
    input  start, f7, f8, f9,
    output x, y, z, busy, done, pass, err_cnt, fail_mask
  );

  modport slave (
    output start, f7, f8, f9,
    input  x, y, z, busy, done, pass, err_cnt, fail_mask
  );
endinterface

// File: rtl/tt_sweep.sv
// Sweeps {x,y,z} over 000..111 and checks f7/f8/f9; done 8*(SETTLE+1) cycles after start.
// TT_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
module tt_sweep #(
  parameter int         SETTLE = 1,
  parameter logic [7:0] EXP7   = 8'hBE,
  parameter logic [7:0] EXP8   = 8'hBE,
  parameter logic [7:0] EXP9   = 8'hBE
) (
  input  logic        clk,
  input  logic        rst,
  tt_sweep_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  logic [3:0] settle_cnt;
  logic [3:0] err_cnt;
  logic [7:0] fail_mask;
  logic       pass;
  logic       mism;
  logic       active;

  assign mism = (bus.f7 != EXP7[idx]) | (bus.f8 != EXP8[idx]) | (bus.f9 != EXP9[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
`ifdef TT_SWEEP_STOP_ON_FAIL_EN
        if (mism || idx == 3'd7) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SETTLE;
        end
`else
        if (idx == 3'd7) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_SETTLE;
        end
`endif
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= 3'd0;
      settle_cnt <= 4'd0;
      err_cnt    <= 4'd0;
      fail_mask  <= 8'h00;
      pass       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            idx        <= 3'd0;
            settle_cnt <= 4'd0;
            err_cnt    <= 4'd0;
            fail_mask  <= 8'h00;
            pass       <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= 4'd0;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (mism) begin
            fail_mask[idx] <= 1'b1;
            err_cnt        <= err_cnt + 4'd1;
          end
          // pass must reflect this final CHECK too, so it is taken from the live compare
          if (state_nxt == S_DONE) begin
            pass <= !mism && (err_cnt == 4'd0);
          end else begin
            idx <= idx + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign active        = (state == S_SETTLE) || (state == S_CHECK);
  assign {bus.x, bus.y, bus.z} = active ? idx : 3'b000;
  assign bus.busy      = active;
  assign bus.done      = (state == S_DONE);
  assign bus.pass      = pass;
  assign bus.err_cnt   = err_cnt;
  assign bus.fail_mask = fail_mask;

endmodule

// File: tb/tb_tt_sweep.sv
// Scoreboarded bench for tt_sweep: SETTLE=1 instance with injectable stuck-at faults, SETTLE=3 instance.
module tb_tt_sweep;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
  localparam bit SOF = 1'b1;
`else
  localparam bit SOF = 1'b0;
`endif

  localparam logic [7:0] TT = 8'hBE;

  typedef struct {
    logic       pass;
    logic [3:0] err;
    logic [7:0] mask;
    int         at;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic f7_stuck0;
  logic f9_stuck1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  tt_sweep_if ia();
  tt_sweep_if ib();

  tt_sweep #(.SETTLE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia));
  tt_sweep #(.SETTLE(3)) dut_b (.clk(clk), .rst(rst), .bus(ib));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ia.f7 = f7_stuck0 ? 1'b0 : TT[{ia.x, ia.y, ia.z}];
  assign ia.f8 = TT[{ia.x, ia.y, ia.z}];
  assign ia.f9 = f9_stuck1 ? 1'b1 : TT[{ia.x, ia.y, ia.z}];
  assign ib.f7 = TT[{ib.x, ib.y, ib.z}];
  assign ib.f8 = TT[{ib.x, ib.y, ib.z}];
  assign ib.f9 = TT[{ib.x, ib.y, ib.z}];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ia.done === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_unexpected_done actual=done required=no_done (cyc %0d)", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_done_cycle", cyc, ea.at);
        chk("a_pass", {31'd0, ia.pass}, {31'd0, ea.pass});
        chk("a_err_cnt", {28'd0, ia.err_cnt}, {28'd0, ea.err});
        chk("a_fail_mask", {24'd0, ia.fail_mask}, {24'd0, ea.mask});
      end
    end
  end

  always @(negedge clk) begin
    if (ib.done === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected_done actual=done required=no_done (cyc %0d)", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_done_cycle", cyc, eb.at);
        chk("b_pass", {31'd0, ib.pass}, {31'd0, eb.pass});
        chk("b_err_cnt", {28'd0, ib.err_cnt}, {28'd0, eb.err});
        chk("b_fail_mask", {24'd0, ib.fail_mask}, {24'd0, eb.mask});
      end
    end
  end

  // Called at a negedge while DUT A is idle; returns at the negedge after E0.
  task automatic go_a(input logic p, input logic [3:0] er, input logic [7:0] m, input int lat);
    exp_t e;
    e.pass = p;
    e.err  = er;
    e.mask = m;
    e.at   = cyc + 1 + lat;
    qa.push_back(e);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
  endtask

  task automatic drain(input bit b, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((b ? qb.size() : qa.size()) == 0) break;
      @(negedge clk);
    end
    chk(b ? "b_drain" : "a_drain", b ? qb.size() : qa.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   c0;
    int   done1;
    int   nb;
    int   bad;
    exp_t e;

    rst       = 1'b1;
    ia.start  = 1'b0;
    ib.start  = 1'b0;
    f7_stuck0 = 1'b0;
    f9_stuck1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_xyz",  {29'd0, ia.x, ia.y, ia.z}, 0);
    chk("rst_busy", {31'd0, ia.busy}, 0);
    chk("rst_done", {31'd0, ia.done}, 0);
    chk("rst_pass", {31'd0, ia.pass}, 0);
    chk("rst_err",  {28'd0, ia.err_cnt}, 0);
    chk("rst_mask", {24'd0, ia.fail_mask}, 0);
    chk("rst_b_busy", {31'd0, ib.busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    // correct responses
    go_a(1'b1, 4'd0, 8'h00, 16);
    chk("t1_busy_after_e0", {31'd0, ia.busy}, 1);
    chk("t1_xyz_first", {29'd0, ia.x, ia.y, ia.z}, 0);
    drain(1'b0, 40);
    chk("t1_hold_pass", {31'd0, ia.pass}, 1);
    chk("t1_idle_busy", {31'd0, ia.busy}, 0);

    // f9 stuck at 1: vectors 000 and 110 mismatch
    f9_stuck1 = 1'b1;
    go_a(1'b0, SOF ? 4'd1 : 4'd2, SOF ? 8'h01 : 8'h41, SOF ? 2 : 16);
    drain(1'b0, 40);
    chk("t2_hold_mask", {24'd0, ia.fail_mask}, SOF ? 32'h01 : 32'h41);
    chk("t2_hold_err", {28'd0, ia.err_cnt}, SOF ? 32'd1 : 32'd2);

    // results cleared at E0; start during sweep ignored
    f9_stuck1 = 1'b0;
    go_a(1'b1, 4'd0, 8'h00, 16);
    chk("t3_cleared_mask", {24'd0, ia.fail_mask}, 0);
    chk("t3_cleared_err", {28'd0, ia.err_cnt}, 0);
    chk("t3_cleared_pass", {31'd0, ia.pass}, 0);
    for (int i = 0; i < 20; i++) begin
      if ({ia.x, ia.y, ia.z} == 3'd3) break;
      @(negedge clk);
    end
    chk("t3_reach_idx3", {29'd0, ia.x, ia.y, ia.z}, 3);
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    drain(1'b0, 40);

    // start held high: back-to-back sweeps, first failing then passing
    f9_stuck1 = 1'b1;
    c0 = cyc;
    done1 = c0 + 1 + (SOF ? 2 : 16);
    e.pass = 1'b0; e.err = SOF ? 4'd1 : 4'd2; e.mask = SOF ? 8'h01 : 8'h41; e.at = done1;
    qa.push_back(e);
    e.pass = 1'b1; e.err = 4'd0; e.mask = 8'h00; e.at = done1 + 2 + 16;
    qa.push_back(e);
    ia.start = 1'b1;
    while (cyc < done1) @(negedge clk);
    f9_stuck1 = 1'b0;
    while (cyc < done1 + 3) @(negedge clk);
    ia.start = 1'b0;
    drain(1'b0, 60);

    // reset mid-SETTLE at idx 5 aborts without done
    ia.start = 1'b1;
    @(negedge clk);
    ia.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ({ia.x, ia.y, ia.z} == 3'd5) break;
      @(negedge clk);
    end
    chk("t4_reach_idx5", {29'd0, ia.x, ia.y, ia.z}, 5);
    #1 rst = 1'b1;
    #1;
    chk("t4_rst_xyz",  {29'd0, ia.x, ia.y, ia.z}, 0);
    chk("t4_rst_busy", {31'd0, ia.busy}, 0);
    chk("t4_rst_done", {31'd0, ia.done}, 0);
    chk("t4_rst_err",  {28'd0, ia.err_cnt}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    go_a(1'b1, 4'd0, 8'h00, 16);
    chk("t4_restart_xyz", {29'd0, ia.x, ia.y, ia.z}, 0);
    chk("t4_restart_busy", {31'd0, ia.busy}, 1);
    drain(1'b0, 40);

    // f7 stuck at 0: mismatches wherever the table is 1
    f7_stuck0 = 1'b1;
    go_a(1'b0, SOF ? 4'd1 : 4'd6, SOF ? 8'h02 : 8'hBE, SOF ? 4 : 16);
    drain(1'b0, 40);

    // every vector mismatches: err_cnt reaches 8
    f9_stuck1 = 1'b1;
    go_a(1'b0, SOF ? 4'd1 : 4'd8, SOF ? 8'h01 : 8'hFF, SOF ? 2 : 16);
    drain(1'b0, 40);
    f7_stuck0 = 1'b0;
    f9_stuck1 = 1'b0;

    // SETTLE=3: 32 busy cycles, each vector held 4 cycles
    e.pass = 1'b1; e.err = 4'd0; e.mask = 8'h00; e.at = cyc + 1 + 32;
    qb.push_back(e);
    ib.start = 1'b1;
    @(negedge clk);
    ib.start = 1'b0;
    nb  = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (ib.busy === 1'b1) begin
        if (int'({ib.x, ib.y, ib.z}) != nb / 4) bad++;
        nb++;
      end
      @(negedge clk);
    end
    chk("b_busy_cycles", nb, 32);
    chk("b_xyz_steps_bad", bad, 0);
    drain(1'b1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
